// File: rtl/regfile_pkg.sv
// Shared types for the register-file write path: register index, data word and
// the pending-write entry used by the write buffer and its bypass matcher.
package regfile_pkg;

  localparam int WORD_W   = 32;
  localparam int IDX_W    = 5;
  localparam int NUM_REGS = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

  typedef struct packed {
    logic     valid;
    reg_idx_t idx;
    word_t    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_bypass_match.sv
// Looks up one register index against all pending write entries and returns the
// youngest matching value; reg 0 never hits.
module wb_bypass_match
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] entries_i,
  input  logic [PTR_W-1:0]      head_i,
  input  reg_idx_t              lookup_i,
  output logic                  hit_o,
  output word_t                 data_o
);

  // Walk oldest to youngest starting at head so later matches override earlier ones.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      logic [PTR_W-1:0] slot;
      slot = head_i + PTR_W'(k);
      if (entries_i[slot].valid && (entries_i[slot].idx == lookup_i) &&
          (lookup_i != ZERO_REG)) begin
        hit_o  = 1'b1;
        data_o = entries_i[slot].data;
      end
    end
  end

endmodule

// File: rtl/regfile_write_buffer.sv
// Circular queue of pending register writes drained one per cycle into the file's
// write port, with two bypass read ports over the not-yet-drained entries.
module regfile_write_buffer
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       in_reg,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    wb_stall,
  output logic                    wb_en,
  output logic [ADDR_W-1:0]       wb_reg,
  output logic [DATA_W-1:0]       wb_data,
  input  logic [ADDR_W-1:0]       read_reg1,
  output logic                    byp_hit1,
  output logic [DATA_W-1:0]       byp_data1,
  input  logic [ADDR_W-1:0]       read_reg2,
  output logic                    byp_hit2,
  output logic [DATA_W-1:0]       byp_data2,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (NUM_REGS != (1 << ADDR_W)) ||
      (DATA_W != WORD_W) || (ADDR_W != IDX_W)) begin : g_param_check
    $error("regfile_write_buffer: unsupported parameter combination");
  end

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  reg_idx_t         idx_q  [DEPTH];
  word_t            data_q [DEPTH];
  wb_entry_t [DEPTH-1:0] entries;
  logic pop, push;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    pop      = !empty && !wb_stall;
    in_ready = !full || pop;
    push     = in_valid && in_ready && (in_reg != ZERO_REG);

    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(push);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Clear before set: when full, pop and push target the same slot.
    vld_d = vld_q;
    if (pop)  vld_d[head_q] = 1'b0;
    if (push) vld_d[tail_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // Payload is qualified by vld_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_q[tail_q]  <= in_reg;
      data_q[tail_q] <= in_data;
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      entries[k] = '{valid: vld_q[k], idx: idx_q[k], data: data_q[k]};
    end
  end

  always_comb begin
    count   = count_q;
    wb_en   = !empty;
    wb_reg  = empty ? '0 : idx_q[head_q];
    wb_data = empty ? '0 : data_q[head_q];
  end

  wb_bypass_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_byp1 (
    .entries_i (entries),
    .head_i    (head_q),
    .lookup_i  (read_reg1),
    .hit_o     (byp_hit1),
    .data_o    (byp_data1)
  );

  wb_bypass_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_byp2 (
    .entries_i (entries),
    .head_i    (head_q),
    .lookup_i  (read_reg2),
    .hit_o     (byp_hit2),
    .data_o    (byp_data2)
  );

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Bench for regfile_write_buffer: directed scenarios plus random traffic, all
// outputs compared every cycle against a queue-based model of pending writes.
module tb_regfile_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_reg = '0;
  logic [31:0] in_data = '0;
  logic        wb_stall = 1'b0;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [4:0]  read_reg1 = '0;
  logic        byp_hit1;
  logic [31:0] byp_data1;
  logic [4:0]  read_reg2 = '0;
  logic        byp_hit2;
  logic [31:0] byp_data2;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  regfile_write_buffer #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_reg    (in_reg),
    .in_data   (in_data),
    .wb_stall  (wb_stall),
    .wb_en     (wb_en),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .read_reg1 (read_reg1),
    .byp_hit1  (byp_hit1),
    .byp_data1 (byp_data1),
    .read_reg2 (read_reg2),
    .byp_hit2  (byp_hit2),
    .byp_data2 (byp_data2),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic lookup(input logic [4:0] rr, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (rr != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].r == rr) begin
          hit = 1'b1;
          d   = q[i].d;
          break;
        end
      end
    end
  endtask

  // Called just after a posedge; drives one cycle, checks at negedge, updates model.
  task automatic cycle(input logic v, input logic [4:0] r, input logic [31:0] d,
                       input logic st, input logic [4:0] r1, input logic [4:0] r2);
    logic exp_ready, pop, push, h1, h2;
    logic [31:0] d1, d2, ed;
    logic [4:0]  er;
    ent_t e;
    in_valid  = v;
    in_reg    = r;
    in_data   = d;
    wb_stall  = st;
    read_reg1 = r1;
    read_reg2 = r2;
    @(negedge clk);
    pop       = (q.size() > 0) && !st;
    exp_ready = (q.size() < DEPTH) || pop;
    push      = v && exp_ready && (r != 0);
    if (q.size() > 0) begin
      er = q[0].r;
      ed = q[0].d;
    end else begin
      er = '0;
      ed = '0;
    end
    lookup(r1, h1, d1);
    lookup(r2, h2, d2);
    check("in_ready", in_ready, exp_ready);
    check("wb_en", wb_en, q.size() > 0);
    check("wb_reg", wb_reg, er);
    check("wb_data", wb_data, ed);
    check("count", count, q.size());
    check("empty", empty, q.size() == 0);
    check("full", full, q.size() == DEPTH);
    check("byp_hit1", byp_hit1, h1);
    check("byp_data1", byp_data1, d1);
    check("byp_hit2", byp_hit2, h2);
    check("byp_data2", byp_data2, d2);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      e.r = r;
      e.d = d;
      q.push_back(e);
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wb_en"}, wb_en, 1'b0);
    check({tag, "_wb_reg"}, wb_reg, 5'd0);
    check({tag, "_wb_data"}, wb_data, 32'd0);
    check({tag, "_count"}, count, 3'd0);
    check({tag, "_empty"}, empty, 1'b1);
    check({tag, "_full"}, full, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_byp_hit1"}, byp_hit1, 1'b0);
    check({tag, "_byp_data1"}, byp_data1, 32'd0);
    check({tag, "_byp_hit2"}, byp_hit2, 1'b0);
    check({tag, "_byp_data2"}, byp_data2, 32'd0);
  endtask

  initial begin
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single write, visible at head and through bypass from the next cycle
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd5);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);

    // Fill under stall, fifth offer held, then accepted alongside the first pop
    for (int i = 1; i <= 4; i++) cycle(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1, 5'(i), 5'd3);
    cycle(1'b1, 5'd5, 32'h105, 1'b1, 5'd4, 5'd5);
    cycle(1'b1, 5'd5, 32'h105, 1'b0, 5'd1, 5'd5);
    for (int i = 0; i < 6; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd2);

    // Youngest pending value for the same register wins
    cycle(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 5'd7);
    cycle(1'b1, 5'd7, 32'h22, 1'b1, 5'd7, 5'd7);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7);
    for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7);

    // Writes to reg 0 are accepted but discarded
    cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);

    // Ten back-to-back pushes with alternating stall to wrap the pointers
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 5'(8 + i), 32'hA000 + 32'(i), 1'(i % 2), 5'(8 + i), 5'(7 + i));
    for (int i = 0; i < 8; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd17);

    // Asynchronous reset with three writes pending
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'(20 + i), 32'hC0 + 32'(i), 1'b1, 5'd20, 5'd21);
    in_valid  = 1'b0;
    wb_stall  = 1'b1;
    read_reg1 = 5'd20;
    read_reg2 = 5'd22;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd20, 5'd22);

    // Random traffic over a small register range to exercise bypass collisions
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
